// File: rtl/mac_seq.sv
// mac_seq: Execute-stage MAC sequencer.
// It accepts MAC and clear instructions, drives a multi-cycle multiplier
// through a start/done handshake, and stalls Execute while a product is
// pending. It owns the architectural accumulator, which updates only when
// the instruction leaves Execute without being flushed.
// Optional feature: define MAC_SAT_EN to saturate the staged sum on signed
// overflow. Without it, the sum wraps modulo 2^XLEN.
module mac_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MacReqE,
  input  logic             MacClrE,
  input  logic             FlushE,
  input  logic             StallM,
  input  logic [XLEN-1:0]  SrcAE,
  input  logic [XLEN-1:0]  SrcBE,
  output logic             MulStart,
  output logic [XLEN-1:0]  MulA,
  output logic [XLEN-1:0]  MulB,
  input  logic             MulDone,
  input  logic [XLEN-1:0]  MulProd,
  output logic             MacStallE,
  output logic             MacValidE,
  output logic [XLEN-1:0]  MacResultE,
  output logic [CNT_W-1:0] MacCount,
  output logic             MacOvf
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;

  state_t           state;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  stage;
  logic             stage_ovf;
  logic [XLEN-1:0]  mul_a;
  logic [XLEN-1:0]  mul_b;
  logic             mul_start;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic             clr_go;
  logic             req_go;
  logic [XLEN-1:0]  sum;
  logic [XLEN-1:0]  sum_final;
  logic             add_ovf;

  // A clear needs Execute to advance, so it waits out a Memory stall.
  // A clear takes priority over a simultaneous (illegal) MAC request.
  assign clr_go = (state == IDLE) && MacClrE && !FlushE && !StallM;
  assign req_go = (state == IDLE) && MacReqE && !MacClrE && !FlushE;

  // Two's-complement add. Overflow occurs when both operand signs match
  // and the sign of the sum differs from them.
  assign sum     = acc + MulProd;
  assign add_ovf = (acc[XLEN-1] == MulProd[XLEN-1]) && (sum[XLEN-1] != acc[XLEN-1]);

`ifdef MAC_SAT_EN
  // Clamp toward the sign of the operands when the add overflows.
  always_comb begin
    sum_final = sum;
    if (add_ovf) begin
      sum_final = acc[XLEN-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
    end
  end
`else
  assign sum_final = sum;
`endif

  // Outputs read 0 while reset is held. This includes the combinational
  // stall and result paths.
  always_comb begin
    MacStallE  = 1'b0;
    MacValidE  = 1'b0;
    MacResultE = '0;
    if (reset_n) begin
      MacStallE = req_go || (state == WAIT) || ((state == DRAIN) && MacReqE);
      if (clr_go) begin
        MacValidE  = 1'b1;
        MacResultE = acc;
      end else if (state == HOLD) begin
        MacValidE  = 1'b1;
        MacResultE = stage;
      end
    end
  end

  assign MulStart = mul_start;
  assign MulA     = mul_a;
  assign MulB     = mul_b;
  assign MacCount = count;
  assign MacOvf   = ovf;

  // Sequencer state, operand capture, staging and accumulator commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      stage     <= '0;
      stage_ovf <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      count     <= '0;
      ovf       <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_go) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end else if (req_go) begin
            mul_a     <= SrcAE;
            mul_b     <= SrcBE;
            mul_start <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (MulDone && !FlushE) begin
            stage     <= sum_final;
            stage_ovf <= add_ovf;
            state     <= HOLD;
          end else if (FlushE && MulDone) begin
            state <= IDLE;
          end else if (FlushE) begin
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (FlushE) begin
            state <= IDLE;
          end else if (!StallM) begin
            acc <= stage;
            if (count != {CNT_W{1'b1}}) begin
              count <= count + CNT_W'(1);
            end
            if (stage_ovf) begin
              ovf <= 1'b1;
            end
            state <= IDLE;
          end
        end
        DRAIN: begin
          // The multiplier is still busy with the flushed operation. Wait
          // for its product, drop it, and only then accept new work.
          if (MulDone) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
